// File: rtl/fast_dac_bank.sv
// fast_dac_bank: per-channel enable/clamp/slew limit, 2 channels interleaved onto each of N_DAC DAC buses.
// Latency: side A on pins 3 edges after the sampling update edge, side B after 4. No backpressure, free-running.
// Optional test-pattern source (tp_en, tp_cnt) built only when FAST_DAC_TESTPAT_EN is defined.
module fast_dac_bank #(
  parameter int N_DAC = 7,
  parameter int W     = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic [2*N_DAC*W-1:0] s_in,
  input  logic [2*N_DAC-1:0]   ch_en,
  input  logic [W-1:0]         lim_lo,
  input  logic [W-1:0]         lim_hi,
  input  logic [W-1:0]         slew_step,
  input  logic                 clip_clr,
`ifdef FAST_DAC_TESTPAT_EN
  input  logic                 tp_en,
`endif
  output logic [N_DAC-1:0]     sel_out,
  output logic [N_DAC*W-1:0]   dac_out,
  output logic [2*N_DAC-1:0]   ramp_busy,
  output logic [2*N_DAC-1:0]   clip_flag,
  output logic                 cfg_err
);
  localparam int NCH = 2 * N_DAC;

  logic                ph;
  logic                upd;
  logic                cfg_err_now;
  logic signed [W-1:0] lo_s;
  logic signed [W-1:0] hi_s;
  logic [W:0]          step_ext;

  logic signed [W-1:0] target_q   [NCH];
  logic signed [W-1:0] cur_q      [NCH];
  logic signed [W-1:0] samp       [NCH];
  logic signed [W-1:0] target_nxt [NCH];
  logic signed [W-1:0] cur_nxt    [NCH];
  logic signed [W:0]   diff       [NCH];
  logic [W:0]          mag        [NCH];
  logic [NCH-1:0]      outside;
  logic [NCH-1:0]      clip_set;

  // Channels advance on the edge that ends the side-B half of the pair.
  assign upd         = ph;
  assign lo_s        = $signed(lim_lo);
  assign hi_s        = $signed(lim_hi);
  assign cfg_err_now = (lo_s > hi_s);
  assign step_ext    = {1'b0, slew_step};

`ifdef FAST_DAC_TESTPAT_EN
  logic [W-1:0] tp_cnt;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      tp_cnt <= '0;
    end else if (upd) begin
      tp_cnt <= tp_cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end
`endif

  // Stage 1: source select, enable, clamp and clip detection.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      samp[k] = s_in[k*W +: W];
`ifdef FAST_DAC_TESTPAT_EN
      if (tp_en) begin
        samp[k] = ((k % 2) == 0) ? tp_cnt : ~tp_cnt;
      end
`endif
      outside[k] = (samp[k] < lo_s) || (samp[k] > hi_s);
      if (cfg_err_now || !ch_en[k]) begin
        target_nxt[k] = '0;
      end else if (samp[k] < lo_s) begin
        target_nxt[k] = lo_s;
      end else if (samp[k] > hi_s) begin
        target_nxt[k] = hi_s;
      end else begin
        target_nxt[k] = samp[k];
      end
      clip_set[k] = upd && ch_en[k] && outside[k] && !cfg_err_now;
`ifdef FAST_DAC_TESTPAT_EN
      clip_set[k] = clip_set[k] && !tp_en;
`endif
    end
  end

  // Stage 2: slew limiter. The W+1 bit difference never wraps; the step is
  // only taken when it falls short of the target, so cur stays in range.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      diff[k] = {target_q[k][W-1], target_q[k]} - {cur_q[k][W-1], cur_q[k]};
      mag[k]  = diff[k][W] ? $unsigned(-diff[k]) : $unsigned(diff[k]);
      if ((slew_step == '0) || (mag[k] <= step_ext)) begin
        cur_nxt[k] = target_q[k];
      end else if (diff[k][W]) begin
        cur_nxt[k] = cur_q[k] - $signed(slew_step);
      end else begin
        cur_nxt[k] = cur_q[k] + $signed(slew_step);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      ph        <= 1'b0;
      cfg_err   <= 1'b0;
      ramp_busy <= '0;
      clip_flag <= '0;
      for (int k = 0; k < NCH; k++) begin
        target_q[k] <= '0;
        cur_q[k]    <= '0;
      end
    end else begin
      ph        <= ~ph;
      cfg_err   <= cfg_err_now;
      clip_flag <= clip_set | (clip_flag & ~{NCH{clip_clr}});
      if (upd) begin
        for (int k = 0; k < NCH; k++) begin
          target_q[k]  <= target_nxt[k];
          cur_q[k]     <= cur_nxt[k];
          ramp_busy[k] <= (cur_nxt[k] != target_nxt[k]);
        end
      end
    end
  end

  // Pin register: all DACs share one phase; select and data move together.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sel_out <= '0;
      dac_out <= '0;
    end else begin
      sel_out <= {N_DAC{ph}};
      for (int d = 0; d < N_DAC; d++) begin
        dac_out[d*W +: W] <= ph ? cur_q[2*d+1] : cur_q[2*d];
      end
    end
  end

endmodule

// File: tb/tb_fast_dac_bank.sv
// Bench for fast_dac_bank: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against an integer model of the channel rules.
module tb_fast_dac_bank;
  localparam int N_DAC = 7;
  localparam int W     = 16;
  localparam int NCH   = 2 * N_DAC;

  logic                 clk_in = 1'b0;
  logic                 rst_n  = 1'b0;
  logic [NCH*W-1:0]     s_in   = '0;
  logic [NCH-1:0]       ch_en  = '1;
  logic [W-1:0]         lim_lo = 16'h8001;
  logic [W-1:0]         lim_hi = 16'h7FFF;
  logic [W-1:0]         slew_step = '0;
  logic                 clip_clr  = 1'b0;
  logic [N_DAC-1:0]     sel_out;
  logic [N_DAC*W-1:0]   dac_out;
  logic [NCH-1:0]       ramp_busy;
  logic [NCH-1:0]       clip_flag;
  logic                 cfg_err;

  fast_dac_bank #(.N_DAC(N_DAC), .W(W)) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .s_in      (s_in),
    .ch_en     (ch_en),
    .lim_lo    (lim_lo),
    .lim_hi    (lim_hi),
    .slew_step (slew_step),
    .clip_clr  (clip_clr),
    .sel_out   (sel_out),
    .dac_out   (dac_out),
    .ramp_busy (ramp_busy),
    .clip_flag (clip_flag),
    .cfg_err   (cfg_err)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;
  int ecnt  = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: channel value per side, pin value per DAC, all as plain integers.
  bit             m_ph;
  int             m_tgt [NCH];
  int             m_cur [NCH];
  int             m_dac [N_DAC];
  bit             m_sel;
  bit [NCH-1:0]   m_busy;
  bit [NCH-1:0]   m_clip;
  bit             m_cfg;
  int             md_lo, md_hi, md_s, md_nt, md_nc;
  bit             md_cerr;

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int approach(input int c, input int t, input int step);
    int d;
    d = t - c;
    if (step == 0 || (d < 0 ? -d : d) <= step) return t;
    return (d > 0) ? c + step : c - step;
  endfunction

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = 1'b0; m_sel = 1'b0; m_busy = '0; m_clip = '0; m_cfg = 1'b0;
      for (int k = 0; k < NCH; k++) begin m_tgt[k] = 0; m_cur[k] = 0; end
      for (int d = 0; d < N_DAC; d++) m_dac[d] = 0;
    end else begin
      md_lo = sx(lim_lo);
      md_hi = sx(lim_hi);
      md_cerr = (md_lo > md_hi);
      for (int d = 0; d < N_DAC; d++) m_dac[d] = m_ph ? m_cur[2*d+1] : m_cur[2*d];
      m_sel = m_ph;
      for (int k = 0; k < NCH; k++) begin
        md_s = sx(s_in[k*W +: W]);
        if (m_ph) begin
          md_nc = approach(m_cur[k], m_tgt[k], int'(slew_step));
          if (md_cerr || !ch_en[k]) md_nt = 0;
          else md_nt = (md_s < md_lo) ? md_lo : ((md_s > md_hi) ? md_hi : md_s);
          m_cur[k] = md_nc;
          m_tgt[k] = md_nt;
          m_busy[k] = (md_nc != md_nt);
        end
        if (m_ph && ch_en[k] && !md_cerr && (md_s < md_lo || md_s > md_hi)) m_clip[k] = 1'b1;
        else if (clip_clr) m_clip[k] = 1'b0;
      end
      m_cfg = md_cerr;
      m_ph = !m_ph;
    end
  end

  logic [N_DAC*W-1:0] e_dac;

  always @(negedge clk_in) begin
    if (chk_on) begin
      for (int d = 0; d < N_DAC; d++) e_dac[d*W +: W] = W'(m_dac[d]);
      chk("dac_out", 128'(dac_out), 128'(e_dac));
      chk("sel_out", 128'(sel_out), 128'({N_DAC{m_sel}}));
      chk("ramp_busy", 128'(ramp_busy), 128'(m_busy));
      chk("clip_flag", 128'(clip_flag), 128'(m_clip));
      chk("cfg_err", 128'(cfg_err), 128'(m_cfg));
    end
  end

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  task automatic do_reset();
    @(posedge clk_in);
    #3 rst_n = 1'b0;
    #4 rst_n = 1'b1;
  endtask

  // Returns 1 time unit after edge n (counted from reset release).
  task automatic goto_edge(input int n);
    int guard;
    guard = 0;
    while (ecnt < n && guard < 500) begin
      @(posedge clk_in);
      #1;
      guard++;
    end
    if (ecnt < n) begin
      total++;
      bad++;
      $display("FAIL goto_edge got=%0d want=%0d", ecnt, n);
    end
  endtask

  task automatic set_all(input logic [W-1:0] v);
    for (int k = 0; k < NCH; k++) s_in[k*W +: W] = v;
  endtask

  logic [W-1:0] rv;

  initial begin
    // Scenario 1: latency of a constant input through both sides.
    set_all(16'h1234);
    do_reset();
    chk_on = 1'b1;
    #1;
    chk("rst_dac", 128'(dac_out), 128'(0));
    chk("rst_sel", 128'(sel_out), 128'(0));
    chk("rst_busy", 128'(ramp_busy), 128'(0));
    chk("rst_clip", 128'(clip_flag), 128'(0));
    chk("rst_cfg", 128'(cfg_err), 128'(0));
    goto_edge(2);
    chk("t1_busy_e2", 128'(ramp_busy[0]), 128'(1));
    goto_edge(4);
    chk("t1_dac0_e4", 128'(dac_out[0 +: W]), 128'(0));
    chk("t1_busy_e4", 128'(ramp_busy[0]), 128'(0));
    goto_edge(5);
    chk("t1_dacA_e5", 128'(dac_out[0 +: W]), 128'(16'h1234));
    chk("t1_selA_e5", 128'(sel_out[0]), 128'(0));
    chk("t1_model_e5", 128'(W'(m_dac[0])), 128'(16'h1234));
    goto_edge(6);
    chk("t1_dacB_e6", 128'(dac_out[0 +: W]), 128'(16'h1234));
    chk("t1_selB_e6", 128'(sel_out[0]), 128'(1));

    // Scenario 2: slew-limited step on ch0.
    set_all(16'h0000);
    slew_step = 16'h0100;
    do_reset();
    goto_edge(3);
    s_in[0 +: W] = 16'h0450;
    goto_edge(7);
    chk("t2_s1", 128'(dac_out[0 +: W]), 128'(16'h0100));
    goto_edge(9);
    chk("t2_s2", 128'(dac_out[0 +: W]), 128'(16'h0200));
    goto_edge(11);
    chk("t2_s3", 128'(dac_out[0 +: W]), 128'(16'h0300));
    goto_edge(13);
    chk("t2_s4", 128'(dac_out[0 +: W]), 128'(16'h0400));
    chk("t2_busy_hi", 128'(ramp_busy[0]), 128'(1));
    goto_edge(15);
    chk("t2_s5", 128'(dac_out[0 +: W]), 128'(16'h0450));
    chk("t2_busy_lo", 128'(ramp_busy[0]), 128'(0));

    // Scenario 3: clamp and sticky clip flag.
    set_all(16'h0000);
    slew_step = '0;
    lim_hi = 16'h1000;
    s_in[3*W +: W] = 16'h7000;
    do_reset();
    goto_edge(2);
    chk("t3_clip_set", 128'(clip_flag[3]), 128'(1));
    goto_edge(6);
    chk("t3_clamped", 128'(dac_out[W +: W]), 128'(16'h1000));
    goto_edge(7);
    clip_clr = 1'b1;
    goto_edge(8);
    chk("t3_set_wins", 128'(clip_flag[3]), 128'(1));
    clip_clr = 1'b0;
    s_in[3*W +: W] = 16'h0800;
    goto_edge(9);
    clip_clr = 1'b1;
    goto_edge(10);
    chk("t3_cleared", 128'(clip_flag[3]), 128'(0));
    clip_clr = 1'b0;

    // Scenario 4: soft stop on disable.
    set_all(16'h0000);
    lim_hi = 16'h7FFF;
    s_in[1*W +: W] = 16'h0300;
    do_reset();
    goto_edge(4);
    slew_step = 16'h0100;
    ch_en[1] = 1'b0;
    goto_edge(6);
    chk("t4_busy", 128'(ramp_busy[1]), 128'(1));
    goto_edge(8);
    chk("t4_b0", 128'(dac_out[0 +: W]), 128'(16'h0300));
    goto_edge(10);
    chk("t4_b1", 128'(dac_out[0 +: W]), 128'(16'h0200));
    goto_edge(12);
    chk("t4_b2", 128'(dac_out[0 +: W]), 128'(16'h0100));
    chk("t4_idle", 128'(ramp_busy[1]), 128'(0));
    goto_edge(14);
    chk("t4_b3", 128'(dac_out[0 +: W]), 128'(16'h0000));
    ch_en = '1;

    // Scenario 5: inverted limits.
    set_all(16'h7000);
    slew_step = '0;
    lim_lo = 16'h0100;
    lim_hi = 16'h0000;
    do_reset();
    goto_edge(1);
    chk("t5_cfg", 128'(cfg_err), 128'(1));
    goto_edge(7);
    chk("t5_dac", 128'(dac_out), 128'(0));
    chk("t5_clip", 128'(clip_flag), 128'(0));

    // Scenario 6: asynchronous reset in the middle of a ramp.
    set_all(16'h7FFF);
    lim_lo = 16'h8001;
    lim_hi = 16'h7FFF;
    slew_step = 16'h0001;
    do_reset();
    goto_edge(20);
    chk("t6_ramp", 128'(dac_out[0 +: W]), 128'(16'h0008));
    chk("t6_busy", 128'(ramp_busy), 128'({NCH{1'b1}}));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_dac", 128'(dac_out), 128'(0));
    chk("t6_rst_sel", 128'(sel_out), 128'(0));
    chk("t6_rst_busy", 128'(ramp_busy), 128'(0));
    #3 rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk_in);
      #1;
      for (int k = 0; k < NCH; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 3))
            0: rv = W'($urandom);
            1: rv = lim_hi + W'($urandom_range(0, 4)) - 16'd2;
            2: rv = lim_lo + W'($urandom_range(0, 4)) - 16'd2;
            default: rv = W'($urandom_range(0, 16'h0400));
          endcase
          s_in[k*W +: W] = rv;
        end
        if ($urandom_range(0, 63) == 0) ch_en[k] = ~ch_en[k];
      end
      if ($urandom_range(0, 63) == 0) begin
        lim_lo = W'(-$urandom_range(0, 16'h7FFF));
        lim_hi = W'($urandom_range(0, 16'h7FFF));
        if ($urandom_range(0, 7) == 0) begin
          rv = lim_lo;
          lim_lo = W'($urandom_range(1, 16'h7FFF));
          lim_hi = rv;
        end
      end
      if ($urandom_range(0, 31) == 0) begin
        case ($urandom_range(0, 2))
          0: slew_step = '0;
          1: slew_step = W'($urandom_range(1, 16'h0200));
          default: slew_step = W'($urandom);
        endcase
      end
      clip_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
    end

    @(posedge clk_in);
    #1;
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
